// File: rtl/relm_custom_arbiter_if.sv
// Requester-side and custom-unit-side buses of relm_custom_arbiter.
// master = requesters plus custom unit, slave = the arbiter.
interface relm_custom_arbiter_if #(
  parameter int WD   = 32,
  parameter int WOP  = 5,
  parameter int WC   = 0,
  parameter int NREQ = 4
);
  localparam int CW = WC + WD;

  logic [NREQ-1:0]     req_in;
  logic [NREQ*WOP-1:0] op_in;
  logic [NREQ*WD-1:0]  a_in;
  logic [NREQ*WD-1:0]  x_in;
  logic [NREQ*CW-1:0]  cb_in;
  logic [NREQ-1:0]     ack_out;
  logic [WD-1:0]       a_out;
  logic [CW-1:0]       cb_out;
  logic                err_out;
  logic                busy_out;

  logic                cu_start_out;
  logic [WOP-1:0]      cu_op_out;
  logic [WD-1:0]       cu_a_out;
  logic [WD-1:0]       cu_x_out;
  logic [CW-1:0]       cu_cb_out;
  logic                cu_done_in;
  logic [WD-1:0]       cu_a_in;
  logic [CW-1:0]       cu_cb_in;

  modport master (
    output req_in, op_in, a_in, x_in, cb_in,
    output cu_done_in, cu_a_in, cu_cb_in,
    input  ack_out, a_out, cb_out, err_out, busy_out,
    input  cu_start_out, cu_op_out, cu_a_out,
    input  cu_x_out, cu_cb_out
  );

  modport slave (
    input  req_in, op_in, a_in, x_in, cb_in,
    input  cu_done_in, cu_a_in, cu_cb_in,
    output ack_out, a_out, cb_out, err_out, busy_out,
    output cu_start_out, cu_op_out, cu_a_out,
    output cu_x_out, cu_cb_out
  );
endinterface

// File: rtl/relm_custom_arbiter.sv
// Round-robin sharing of one multi-cycle relm_custom unit among NREQ requesters.
// Optional WAIT timeout enabled by defining RELM_CUSTOM_TIMEOUT_EN.
module relm_custom_arbiter #(
  parameter int WD      = 32,
  parameter int WOP     = 5,
  parameter int WC      = 0,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 256
) (
  input logic                 clk,
  input logic                 rst,
  relm_custom_arbiter_if.slave bus
);
  localparam int CW = WC + WD;
  localparam int GW = $clog2(NREQ);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]     state_q, state_d;
  logic [GW-1:0]  rr_q, rr_d;
  logic [GW-1:0]  g_q, g_d;
  logic [WOP-1:0] op_q, op_d;
  logic [WD-1:0]  a_q, a_d;
  logic [WD-1:0]  x_q, x_d;
  logic [CW-1:0]  cb_q, cb_d;
  logic [WD-1:0]  ra_q, ra_d;
  logic [CW-1:0]  rcb_q, rcb_d;
  logic           err_q, err_d;

  logic           gnt_vld;
  logic [GW-1:0]  gnt_idx;
  logic           tmo;

  // Scan downwards so the lowest offset from rr_q wins.
  always_comb begin
    int idx;
    idx     = 0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(rr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (bus.req_in[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = GW'(idx);
      end
    end
  end

`ifdef RELM_CUSTOM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT);

  logic [TW-1:0] cnt_q;

  assign tmo = (cnt_q == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (state_q != S_WAIT) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
`else
  logic unused_tmo;

  assign tmo        = 1'b0;
  assign unused_tmo = (TIMEOUT != 0);
`endif

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    g_d     = g_q;
    op_d    = op_q;
    a_d     = a_q;
    x_d     = x_q;
    cb_d    = cb_q;
    ra_d    = ra_q;
    rcb_d   = rcb_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (gnt_vld) begin
          state_d = S_ISSUE;
          g_d     = gnt_idx;
          op_d    = bus.op_in[gnt_idx*WOP +: WOP];
          a_d     = bus.a_in[gnt_idx*WD +: WD];
          x_d     = bus.x_in[gnt_idx*WD +: WD];
          cb_d    = bus.cb_in[gnt_idx*CW +: CW];
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // done beats a coincident timeout
        if (bus.cu_done_in) begin
          state_d = S_RESP;
          ra_d    = bus.cu_a_in;
          rcb_d   = bus.cu_cb_in;
          err_d   = 1'b0;
        end else if (tmo) begin
          state_d = S_RESP;
          ra_d    = '1;
          rcb_d   = '0;
          err_d   = 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        rr_d    = (g_q == GW'(NREQ - 1)) ? '0 : g_q + 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      g_q     <= '0;
      op_q    <= '0;
      a_q     <= '0;
      x_q     <= '0;
      cb_q    <= '0;
      ra_q    <= '0;
      rcb_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      g_q     <= g_d;
      op_q    <= op_d;
      a_q     <= a_d;
      x_q     <= x_d;
      cb_q    <= cb_d;
      ra_q    <= ra_d;
      rcb_q   <= rcb_d;
      err_q   <= err_d;
    end
  end

  logic resp;
  assign resp = (state_q == S_RESP);

  assign bus.ack_out      = resp ? (NREQ'(1) << g_q) : '0;
  assign bus.a_out        = resp ? ra_q : '0;
  assign bus.cb_out       = resp ? rcb_q : '0;
  assign bus.err_out      = resp & err_q;
  assign bus.busy_out     = (state_q != S_IDLE);
  assign bus.cu_start_out = (state_q == S_ISSUE);
  assign bus.cu_op_out    = op_q;
  assign bus.cu_a_out     = a_q;
  assign bus.cu_x_out     = x_q;
  assign bus.cu_cb_out    = cb_q;
endmodule

// File: tb/tb_relm_custom_arbiter.sv
// Self-checking bench for relm_custom_arbiter: directed steps plus
// randomized operations against a round-robin reference model.
module tb_relm_custom_arbiter;
  localparam int WD   = 32;
  localparam int WOP  = 5;
  localparam int WC   = 0;
  localparam int NREQ = 4;
  localparam int TMO  = 8;
  localparam int CW   = WC + WD;

  logic clk = 1'b0;
  logic rst = 1'b1;

  relm_custom_arbiter_if #(
    .WD(WD), .WOP(WOP), .WC(WC), .NREQ(NREQ)
  ) bus ();

  relm_custom_arbiter #(
    .WD(WD), .WOP(WOP), .WC(WC), .NREQ(NREQ), .TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [NREQ-1:0] req_m;
  logic [WOP-1:0]  op_m[NREQ];
  logic [WD-1:0]   a_m[NREQ];
  logic [WD-1:0]   x_m[NREQ];
  logic [CW-1:0]   cb_m[NREQ];
  int              rr_m = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    bus.req_in = req_m;
    for (int i = 0; i < NREQ; i++) begin
      bus.op_in[i*WOP +: WOP] = op_m[i];
      bus.a_in[i*WD +: WD]    = a_m[i];
      bus.x_in[i*WD +: WD]    = x_m[i];
      bus.cb_in[i*CW +: CW]   = cb_m[i];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic new_opnd(input int i);
    op_m[i] = WOP'($urandom);
    a_m[i]  = $urandom;
    x_m[i]  = $urandom;
    cb_m[i] = CW'($urandom);
  endtask

  // Reference grant: first requester at or after the pointer, wrapping.
  function automatic int pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++)
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return 0;
  endfunction

  // Full operation from an IDLE cycle; unit answers lat cycles after start.
  task automatic do_op(input int lat, input logic [WD-1:0] ra,
                       input logic [CW-1:0] rcb, input logic [NREQ-1:0] up,
                       input bit rnd, output logic [NREQ-1:0] obs);
    int              g;
    logic [WOP-1:0]  eop;
    logic [WD-1:0]   ea, ex;
    logic [CW-1:0]   ecb;
    logic [NREQ-1:0] eack;
    g    = pick(req_m, rr_m);
    eop  = op_m[g];
    ea   = a_m[g];
    ex   = x_m[g];
    ecb  = cb_m[g];
    eack = '0;
    eack[g] = 1'b1;
    bus.cu_done_in = 1'b0;
    drive();
    tick();
    chk("start", bus.cu_start_out, 1);
    chk("busy_issue", bus.busy_out, 1);
    chk("ack_issue", bus.ack_out, 0);
    chk("cu_op", bus.cu_op_out, eop);
    chk("cu_a", bus.cu_a_out, ea);
    chk("cu_x", bus.cu_x_out, ex);
    chk("cu_cb", bus.cu_cb_out, ecb);
    for (int i = 0; i < NREQ; i++)
      if (i != g && !req_m[i] &&
          (up[i] || (rnd && $urandom_range(0, 2) == 0))) begin
        req_m[i] = 1'b1;
        new_opnd(i);
      end
    if (rnd && $urandom_range(0, 3) == 0) req_m[g] = 1'b0;
    drive();
    for (int c = 1; c < lat; c++) begin
      tick();
      chk("start_wait", bus.cu_start_out, 0);
      chk("ack_wait", bus.ack_out, 0);
      chk("aout_wait", bus.a_out, 0);
    end
    tick();
    chk("start_once", bus.cu_start_out, 0);
    chk("hold_op", bus.cu_op_out, eop);
    chk("hold_a", bus.cu_a_out, ea);
    chk("hold_x", bus.cu_x_out, ex);
    bus.cu_done_in = 1'b1;
    bus.cu_a_in    = ra;
    bus.cu_cb_in   = rcb;
    tick();
    bus.cu_done_in = 1'b0;
    bus.cu_a_in    = $urandom;
    bus.cu_cb_in   = CW'($urandom);
    obs = bus.ack_out;
    chk("ack", bus.ack_out, eack);
    chk("a_out", bus.a_out, ra);
    chk("cb_out", bus.cb_out, rcb);
    chk("err_ok", bus.err_out, 0);
    chk("busy_resp", bus.busy_out, 1);
    req_m[g] = 1'b0;
    drive();
    rr_m = (g + 1) % NREQ;
    tick();
    chk("ack_pulse", bus.ack_out, 0);
    chk("a_zero", bus.a_out, 0);
    chk("cb_zero", bus.cb_out, 0);
    chk("busy_idle", bus.busy_out, 0);
  endtask

  initial begin
    logic [NREQ-1:0] obs;
    int              order[5];
    order = '{0, 1, 2, 3, 0};
    bus.cu_done_in = 1'b0;
    bus.cu_a_in    = '0;
    bus.cu_cb_in   = '0;
    for (int i = 0; i < NREQ; i++) new_opnd(i);

    // reset with all requests high
    rst   = 1'b1;
    req_m = '1;
    drive();
    tick();
    chk("rst_start0", bus.cu_start_out, 0);
    tick();
    chk("rst_start1", bus.cu_start_out, 0);
    chk("rst_busy", bus.busy_out, 0);
    chk("rst_ack", bus.ack_out, 0);
    chk("rst_a", bus.a_out, 0);
    chk("rst_cb", bus.cb_out, 0);
    chk("rst_err", bus.err_out, 0);
    chk("rst_cu_op", bus.cu_op_out, 0);
    chk("rst_cu_a", bus.cu_a_out, 0);
    chk("rst_cu_x", bus.cu_x_out, 0);
    chk("rst_cu_cb", bus.cu_cb_out, 0);
    req_m = '0;
    drive();
    rst = 1'b0;
    tick();
    chk("idle_noreq", bus.busy_out, 0);

    // single request, a=5 x=7 -> 12
    req_m = 4'b0010;
    a_m[1] = 32'd5;
    x_m[1] = 32'd7;
    do_op(1, a_m[1] + x_m[1], CW'(0), '0, 1'b0, obs);
    chk("single_ack", obs, 4'b0010);

    // round robin with all requesters re-raising after their ack
    rst = 1'b1;
    tick();
    rst  = 1'b0;
    rr_m = 0;
    req_m = '1;
    for (int i = 0; i < NREQ; i++) new_opnd(i);
    for (int k = 0; k < 5; k++) begin
      logic [NREQ-1:0] e;
      do_op(1, $urandom, CW'($urandom), '0, 1'b0, obs);
      e = '0;
      e[order[k]] = 1'b1;
      chk("rr_order", obs, e);
      for (int i = 0; i < NREQ; i++)
        if (!req_m[i]) begin
          req_m[i] = 1'b1;
          new_opnd(i);
        end
    end

    // hold-off: req[2] rises while req[0] is in WAIT
    req_m = 4'b0001;
    do_op(3, $urandom, CW'($urandom), 4'b0100, 1'b0, obs);
    chk("holdoff_first", obs, 4'b0001);
    do_op(2, $urandom, CW'($urandom), '0, 1'b0, obs);
    chk("holdoff_next", obs, 4'b0100);

    // reset while in WAIT abandons the operation
    req_m = 4'b0100;
    new_opnd(2);
    drive();
    tick();
    chk("rw_start", bus.cu_start_out, 1);
    tick();
    rst = 1'b1;
    tick();
    rst   = 1'b0;
    req_m = '0;
    drive();
    chk("rw_busy", bus.busy_out, 0);
    chk("rw_cu_a", bus.cu_a_out, 0);
    bus.cu_done_in = 1'b1;
    bus.cu_a_in    = 32'hDEAD_BEEF;
    tick();
    bus.cu_done_in = 1'b0;
    chk("rw_noack0", bus.ack_out, 0);
    chk("rw_busy0", bus.busy_out, 0);
    tick();
    chk("rw_noack1", bus.ack_out, 0);
    rr_m  = 0;
    req_m = '1;
    for (int i = 0; i < NREQ; i++) new_opnd(i);
    do_op(1, $urandom, CW'($urandom), '0, 1'b0, obs);
    chk("rw_rr0", obs, 4'b0001);

    // unit never answers
    req_m = 4'b1000;
    drive();
    tick();
    chk("to_start", bus.cu_start_out, 1);
`ifdef RELM_CUSTOM_TIMEOUT_EN
    begin
      int n;
      bit seen;
      n    = 0;
      seen = 1'b0;
      while (!seen && n < TMO + 4) begin
        tick();
        n++;
        if (bus.ack_out != 0) seen = 1'b1;
      end
      chk("to_seen", seen, 1);
      chk("to_ack", bus.ack_out, 4'b1000);
      chk("to_err", bus.err_out, 1);
      chk("to_a", bus.a_out, 64'hFFFF_FFFF);
      chk("to_cb", bus.cb_out, 0);
      req_m = '0;
      drive();
      tick();
      chk("to_idle", bus.busy_out, 0);
      rr_m = 0;
    end
`else
    repeat (100) tick();
    chk("to_busy", bus.busy_out, 1);
    chk("to_noack", bus.ack_out, 0);
    chk("to_noerr", bus.err_out, 0);
    rst   = 1'b1;
    req_m = '0;
    drive();
    tick();
    rst  = 1'b0;
    rr_m = 0;
    chk("to_rst", bus.busy_out, 0);
`endif

    // randomized traffic
    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < NREQ; i++)
        if (!req_m[i] && $urandom_range(0, 2) == 0) begin
          req_m[i] = 1'b1;
          new_opnd(i);
        end
      if (req_m == '0) begin
        int j;
        j = $urandom_range(0, NREQ - 1);
        req_m[j] = 1'b1;
        new_opnd(j);
      end
      do_op($urandom_range(1, 4), $urandom, CW'($urandom), '0, 1'b1, obs);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
